// File: rtl/rectangle80_decrypt_if.sv
// Request/response bundle for the RECTANGLE-80 decryption core.
// Ports: Start, cipherText, key (requester to core); plainText, plainReady, Busy (core to requester).
interface rectangle80_decrypt_if;
    logic        Start;
    logic [63:0] cipherText;
    logic [79:0] key;
    logic [63:0] plainText;
    logic        plainReady;
    logic        Busy;

    modport master (
        output Start,
        output cipherText,
        output key,
        input  plainText,
        input  plainReady,
        input  Busy
    );

    modport slave (
        input  Start,
        input  cipherText,
        input  key,
        output plainText,
        output plainReady,
        output Busy
    );
endinterface

// File: rtl/rectangle80_decrypt.sv
// Iterative RECTANGLE-80 decryption: expands all round keys forward into a key file, then runs inverse rounds.
// Ports: Clk, RstN (async active-low), Enable (global advance), bus (slave side of rectangle80_decrypt_if).
module rectangle80_decrypt #(
    parameter int ROUNDS = 25
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 Enable,
    rectangle80_decrypt_if.slave bus
);

    // Nibble tables packed with entry 0 in the low nibble.
    localparam logic [63:0] SBOX = 64'h24F8_D30B_97E1_AC56;
    localparam logic [63:0] SINV = 64'hD5B2_837C_601E_AF49;
    localparam logic [4:0]  LAST = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DECRYPT
    } fsm_t;

    fsm_t        fsm;
    logic [4:0]  cnt;
    logic [4:0]  rc;
    logic [63:0] state_q;
    logic [79:0] kreg;
    logic [63:0] kfile [ROUNDS+1];
    logic [63:0] plain_q;
    logic        ready_q;
    logic        busy_q;

    logic [79:0] step;
    logic [63:0] inv;
    logic [4:0]  rc_next;

    function automatic logic [3:0] sub(input logic [63:0] tbl,
                                       input logic [3:0]  x);
        return tbl[{x, 2'b00} +: 4];
    endfunction

    // Forward key schedule step; the S-box touches only columns 0..3
    // of rows 0..3, and row4' takes the substituted row0.
    function automatic logic [79:0] key_step(input logic [79:0] k,
                                             input logic [4:0]  c);
        logic [15:0] r [5];
        logic [15:0] o0;
        logic [15:0] o3;
        logic [3:0]  n;
        for (int i = 0; i < 5; i++) begin
            r[i] = k[16*i +: 16];
        end
        for (int j = 0; j < 4; j++) begin
            n = {r[3][j], r[2][j], r[1][j], r[0][j]};
            n = sub(SBOX, n);
            {r[3][j], r[2][j], r[1][j], r[0][j]} = n;
        end
        o0      = {r[0][7:0], r[0][15:8]} ^ r[1];
        o3      = {r[3][3:0], r[3][15:4]} ^ r[4];
        o0[4:0] = o0[4:0] ^ c;
        return {r[0], o3, r[3], r[2], o0};
    endfunction

    // InvShiftRow, InvSubColumn, then round-key addition.
    function automatic logic [63:0] inv_round(input logic [63:0] s,
                                              input logic [63:0] rk);
        logic [15:0] r [4];
        logic [3:0]  n;
        r[0] = s[15:0];
        r[1] = {s[16],  s[31:17]};
        r[2] = {s[43:32], s[47:44]};
        r[3] = {s[60:48], s[63:61]};
        for (int j = 0; j < 16; j++) begin
            n = {r[3][j], r[2][j], r[1][j], r[0][j]};
            n = sub(SINV, n);
            {r[3][j], r[2][j], r[1][j], r[0][j]} = n;
        end
        return {r[3], r[2], r[1], r[0]} ^ rk;
    endfunction

    assign step    = key_step(kreg, rc);
    assign inv     = inv_round(state_q, kfile[cnt]);
    assign rc_next = {rc[3:0], rc[4] ^ rc[2]};

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            fsm     <= IDLE;
            cnt     <= '0;
            rc      <= 5'h01;
            state_q <= '0;
            kreg    <= '0;
            plain_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i <= ROUNDS; i++) begin
                kfile[i] <= '0;
            end
        end else if (Enable) begin
            ready_q <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (bus.Start) begin
                        state_q  <= bus.cipherText;
                        kreg     <= bus.key;
                        kfile[0] <= bus.key[63:0];
                        rc       <= 5'h01;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        fsm      <= EXPAND;
                    end
                end
                EXPAND: begin
                    kreg             <= step;
                    kfile[cnt+5'd1]  <= step[63:0];
                    rc               <= rc_next;
                    // Last subkey is whitened into the state on the
                    // same edge it is written; cnt parks at the top.
                    if (cnt == LAST) begin
                        state_q <= state_q ^ step[63:0];
                        fsm     <= DECRYPT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DECRYPT: begin
                    state_q <= inv;
                    if (cnt == 5'd0) begin
                        plain_q <= inv;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        fsm     <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.plainText  = plain_q;
    assign bus.plainReady = ready_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_rectangle80_decrypt.sv
// Self-checking bench for rectangle80_decrypt: ciphertexts come from an in-bench encrypt model.
// Ports: drives Clk/RstN/Enable and the master side of rectangle80_decrypt_if.
module tb_rectangle80_decrypt;

    logic Clk = 1'b0;
    logic RstN = 1'b0;
    logic Enable = 1'b0;

    rectangle80_decrypt_if bus();

    rectangle80_decrypt dut (
        .Clk    (Clk),
        .RstN   (RstN),
        .Enable (Enable),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int sbox_t [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    // Reference RECTANGLE-80 encryption in row/column form.
    function automatic logic [63:0] encrypt(input logic [63:0] pt,
                                            input logic [79:0] k);
        logic [15:0] kr [5];
        logic [15:0] s [4];
        logic [15:0] t [5];
        logic [63:0] rk [26];
        logic [3:0]  nib;
        int          v;
        int          rc;
        rc = 1;
        for (int i = 0; i < 5; i++) kr[i] = k[16*i +: 16];
        for (int r = 0; r < 26; r++) begin
            rk[r] = {kr[3], kr[2], kr[1], kr[0]};
            for (int j = 0; j < 4; j++) begin
                nib = {kr[3][j], kr[2][j], kr[1][j], kr[0][j]};
                v = sbox_t[nib];
                for (int b = 0; b < 4; b++) kr[b][j] = v[b];
            end
            t[0] = rotl(kr[0], 8) ^ kr[1];
            t[1] = kr[2];
            t[2] = kr[3];
            t[3] = rotl(kr[3], 12) ^ kr[4];
            t[4] = kr[0];
            t[0] = t[0] ^ 16'(rc);
            for (int i = 0; i < 5; i++) kr[i] = t[i];
            rc = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
        end
        for (int i = 0; i < 4; i++) s[i] = pt[16*i +: 16];
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ rk[r][16*i +: 16];
            for (int j = 0; j < 16; j++) begin
                nib = {s[3][j], s[2][j], s[1][j], s[0][j]};
                v = sbox_t[nib];
                for (int b = 0; b < 4; b++) s[b][j] = v[b];
            end
            s[1] = rotl(s[1], 1);
            s[2] = rotl(s[2], 12);
            s[3] = rotl(s[3], 13);
        end
        return {s[3], s[2], s[1], s[0]} ^ rk[25];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [79:0] rnd80();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [63:0] pt, input logic [79:0] k);
        bus.cipherText = encrypt(pt, k);
        bus.key        = k;
    endtask

    task automatic start_req(input logic [63:0] pt, input logic [79:0] k);
        load(pt, k);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!bus.plainReady && lat < limit) begin
            if (bus.Busy) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.plainReady) p++;
        end
    endtask

    logic [63:0] pa, pb, pc;
    logic [79:0] ka, kb, kc;
    logic [63:0] pts [3];
    logic [79:0] kys [3];
    int lat, bc, pulses;

    initial begin
        bus.Start      = 1'b0;
        bus.cipherText = '0;
        bus.key        = '0;
        Enable         = 1'b1;
        RstN           = 1'b0;
        repeat (3) tick();
        chk("reset_plaintext", bus.plainText, 0);
        chk("reset_ready", bus.plainReady, 0);
        chk("reset_busy", bus.Busy, 0);
        RstN = 1'b1;
        tick();

        // Golden all-zero vector.
        start_req(64'h0, 80'h0);
        wait_done(80, lat, bc);
        chk("zero_latency", lat, 50);
        chk("zero_busy_cycles", bc, 50);
        chk("zero_plaintext", bus.plainText, 64'h0);
        tick();
        chk("zero_pulse_drop", bus.plainReady, 0);
        chk("zero_busy_low", bus.Busy, 0);

        // Round-trip vector.
        pa = 64'h1234_56AB_CD13_2536;
        ka = 80'h0123_4567_89AB_CDEF_0011;
        start_req(pa, ka);
        wait_done(80, lat, bc);
        chk("rt_latency", lat, 50);
        chk("rt_plaintext", bus.plainText, pa);
        repeat (4) tick();
        chk("rt_plain_held", bus.plainText, pa);

        // Random round trips.
        for (int i = 0; i < 3; i++) begin
            pa = rnd64();
            ka = rnd80();
            start_req(pa, ka);
            wait_done(80, lat, bc);
            chk("rand_latency", lat, 50);
            chk("rand_plaintext", bus.plainText, pa);
            tick();
        end

        // Starts during a run are ignored.
        pa = rnd64(); ka = rnd80();
        pb = rnd64(); kb = rnd80();
        pc = rnd64(); kc = rnd80();
        start_req(pa, ka);
        repeat (9) tick();
        start_req(pb, kb);
        repeat (19) tick();
        start_req(pc, kc);
        wait_done(60, lat, bc);
        chk("ign_latency", 30 + lat, 50);
        chk("ign_plaintext", bus.plainText, pa);
        count_pulses(60, pulses);
        chk("ign_extra_pulses", pulses, 0);

        // Enable stalls in EXPAND and DECRYPT.
        pa = rnd64(); ka = rnd80();
        start_req(pa, ka);
        repeat (4) tick();
        Enable = 1'b0;
        repeat (7) tick();
        Enable = 1'b1;
        repeat (26) tick();
        Enable = 1'b0;
        repeat (5) tick();
        Enable = 1'b1;
        wait_done(60, lat, bc);
        chk("stall_latency", 4 + 7 + 26 + 5 + lat, 62);
        chk("stall_plaintext", bus.plainText, pa);
        Enable = 1'b0;
        repeat (3) tick();
        chk("stall_ready_held", bus.plainReady, 1);
        chk("stall_plain_held", bus.plainText, pa);
        Enable = 1'b1;
        tick();
        chk("stall_ready_drop", bus.plainReady, 0);

        // Reset mid-operation.
        pa = rnd64(); ka = rnd80();
        start_req(pa, ka);
        repeat (20) tick();
        RstN = 1'b0;
        #1;
        chk("rst_plaintext", bus.plainText, 0);
        chk("rst_ready", bus.plainReady, 0);
        chk("rst_busy", bus.Busy, 0);
        count_pulses(3, pulses);
        RstN = 1'b1;
        tick();
        chk("rst_busy_after", bus.Busy, 0);
        count_pulses(60, bc);
        chk("rst_no_pulse", pulses + bc, 0);
        pb = rnd64(); kb = rnd80();
        start_req(pb, kb);
        wait_done(80, lat, bc);
        chk("rst_new_latency", lat, 50);
        chk("rst_new_plaintext", bus.plainText, pb);
        tick();

        // Back-to-back with Start held high.
        for (int i = 0; i < 3; i++) begin
            pts[i] = rnd64();
            kys[i] = rnd80();
        end
        load(pts[0], kys[0]);
        bus.Start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) load(pts[i+1], kys[i+1]);
            else bus.Start = 1'b0;
            wait_done(80, lat, bc);
            chk("b2b_latency", lat, 50);
            chk("b2b_plaintext", bus.plainText, pts[i]);
            if (i < 2) tick();
        end
        count_pulses(60, pulses);
        chk("b2b_tail_pulses", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
